// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - lamp codes and detector state encodings shared with the controller
package traffic_pkg;

  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_RED = 3'b100;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    QUAL  = 3'd1,
    REQ   = 3'd2,
    SERVE = 3'd3,
    COOL  = 3'd4
  } det_state_t;

  function automatic logic lamp_legal(input logic [2:0] lamp);
    return (lamp == LAMP_GRN) || (lamp == LAMP_YEL) || (lamp == LAMP_RED);
  endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// rtl/tl_tick_gen.sv - free-running divide-by-TICK_DIV sample enable
module tl_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/farm_road_detector.sv
// rtl/farm_road_detector.sv - debounced, latched farm-road vehicle request with cool-down
// Optional served-request counter: define FARM_REQ_STATS_EN.
module farm_road_detector
  import traffic_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int DEB_TICKS  = 3,
  parameter int HOLD_TICKS = 2
`ifdef FARM_REQ_STATS_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det_raw,
  input  logic [2:0]       l_f,
  output logic             C,
  output logic             served,
  output logic             lamp_err
`ifdef FARM_REQ_STATS_EN
  ,
  output logic [CNT_W-1:0] req_count
`endif
);

  localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  logic          sync1, det_s, tick;
  det_state_t    state, state_nxt;
  logic [DW-1:0] deb_cnt, deb_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          c_nxt, served_nxt;

  tl_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b0;
      det_s    <= 1'b0;
      state    <= IDLE;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      C        <= 1'b0;
      served   <= 1'b0;
      lamp_err <= 1'b0;
    end else begin
      sync1    <= det_raw;
      det_s    <= sync1;
      state    <= state_nxt;
      deb_cnt  <= deb_nxt;
      hold_cnt <= hold_nxt;
      C        <= c_nxt;
      served   <= served_nxt;
      lamp_err <= lamp_err | ~lamp_legal(l_f);
    end
  end

  // An illegal lamp code matches neither green nor red, so REQ and SERVE simply hold.
  always_comb begin
    state_nxt = state;
    deb_nxt   = deb_cnt;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (det_s) begin
          state_nxt = QUAL;
          deb_nxt   = '0;
        end
      end
      QUAL: begin
        if (!det_s) begin
          state_nxt = IDLE;
        end else if (tick) begin
          if (deb_cnt == DEB_LAST) state_nxt = REQ;
          else deb_nxt = deb_cnt + 1'b1;
        end
      end
      REQ: begin
        if (l_f == LAMP_GRN) state_nxt = SERVE;
      end
      SERVE: begin
        if (l_f == LAMP_RED) begin
          state_nxt = COOL;
          hold_nxt  = '0;
        end
      end
      COOL: begin
        if (tick) begin
          if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
          else hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // C decodes the next state so it rises on the same edge the FSM enters REQ.
  always_comb begin
    c_nxt      = (state_nxt == REQ);
    served_nxt = (state == SERVE) && (l_f == LAMP_RED);
  end

`ifdef FARM_REQ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_count <= '0;
    end else if (served && (req_count != {CNT_W{1'b1}})) begin
      req_count <= req_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_farm_road_detector.sv
// tb/tb_farm_road_detector.sv - self-checking bench for farm_road_detector
module tb_farm_road_detector;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       det_raw = 1'b0;
  logic [2:0] l_f = LAMP_RED;
  logic       C, served, lamp_err;
`ifdef FARM_REQ_STATS_EN
  logic [15:0] req_count;
`endif

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  farm_road_detector dut (
    .clk      (clk),
    .rst      (rst),
    .det_raw  (det_raw),
    .l_f      (l_f),
    .C        (C),
    .served   (served),
    .lamp_err (lamp_err)
`ifdef FARM_REQ_STATS_EN
    ,
    .req_count(req_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (served) pulses++;

  typedef struct {
    logic [2:0] lamp;
    logic       exp_err;
  } lamp_vec_t;

  lamp_vec_t lamp_tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    det_raw = 1'b0;
    l_f = LAMP_RED;
    step(2);
    rst = 1'b1;
  endtask

  task automatic wait_c(input int budget, output int n);
    n = 0;
    while (!C && n < budget) begin
      step(1);
      n++;
    end
  endtask

  task automatic serve_cycle(input int idx);
    int n;
    det_raw = 1'b1;
    wait_c(40, n);
    chk($sformatf("stats_req_%0d", idx), {31'd0, C}, 32'd1);
    det_raw = 1'b0;
    l_f = LAMP_GRN;
    step(1);
    l_f = LAMP_RED;
    step(1);
    chk($sformatf("stats_served_%0d", idx), {31'd0, served}, 32'd1);
    step(12);
  endtask

  initial begin
    int n;
    int p0;
    logic seen;

    lamp_tbl[0] = '{3'b000, 1'b1};
    lamp_tbl[1] = '{3'b001, 1'b0};
    lamp_tbl[2] = '{3'b010, 1'b0};
    lamp_tbl[3] = '{3'b011, 1'b1};
    lamp_tbl[4] = '{3'b100, 1'b0};
    lamp_tbl[5] = '{3'b101, 1'b1};
    lamp_tbl[6] = '{3'b110, 1'b1};
    lamp_tbl[7] = '{3'b111, 1'b1};

    do_reset();
    chk("reset_c", {31'd0, C}, 32'd0);
    chk("reset_served", {31'd0, served}, 32'd0);
    chk("reset_lamp_err", {31'd0, lamp_err}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      l_f = lamp_tbl[i].lamp;
      step(1);
      chk($sformatf("lamp_err_%03b", lamp_tbl[i].lamp), {31'd0, lamp_err}, {31'd0, lamp_tbl[i].exp_err});
    end

    // Glitch: 6-clk pulse never completes three ticks of qualification.
    do_reset();
    det_raw = 1'b1;
    step(6);
    det_raw = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (C) seen = 1'b1;
    end
    chk("glitch_no_c", {31'd0, seen}, 32'd0);
    chk("glitch_idle", {29'd0, dut.state}, {29'd0, IDLE});

    // Steady detector: C within 15 clk, then latched.
    do_reset();
    det_raw = 1'b1;
    wait_c(20, n);
    chk("rise_within_15", {31'd0, (n <= 15)}, 32'd1);
    seen = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (!C) seen = 1'b0;
    end
    chk("c_held", {31'd0, seen}, 32'd1);

    // Grant: C latched after detector drops, falls one clk after green.
    det_raw = 1'b0;
    step(5);
    chk("c_latched", {31'd0, C}, 32'd1);
    l_f = LAMP_GRN;
    step(1);
    chk("c_fall_on_green", {31'd0, C}, 32'd0);
    p0 = pulses;
    l_f = LAMP_YEL;
    step(3);
    chk("no_served_on_yellow", {31'd0, served}, 32'd0);
    l_f = LAMP_RED;
    det_raw = 1'b1;
    step(1);
    chk("served_pulse", {31'd0, served}, 32'd1);
    step(1);
    chk("served_drops", {31'd0, served}, 32'd0);
    chk("served_once", pulses - p0, 32'd1);

    // Cool-down: detector held high, C stays low until cool-down plus a fresh qualification.
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (C) seen = 1'b1;
    end
    chk("cool_no_c", {31'd0, seen}, 32'd0);
    wait_c(40, n);
    chk("c_after_cool", {31'd0, C}, 32'd1);

    // Illegal lamp in REQ: sticky error, state unchanged.
    l_f = 3'b011;
    step(1);
    chk("illegal_err_set", {31'd0, lamp_err}, 32'd1);
    chk("illegal_c_held", {31'd0, C}, 32'd1);
    l_f = LAMP_RED;
    step(3);
    chk("illegal_err_sticky", {31'd0, lamp_err}, 32'd1);
    chk("illegal_state_req", {29'd0, dut.state}, {29'd0, REQ});

    // Asynchronous reset while C=1.
    rst = 1'b0;
    #1;
    chk("async_rst_c", {31'd0, C}, 32'd0);
    chk("async_rst_err", {31'd0, lamp_err}, 32'd0);
    det_raw = 1'b0;
    step(1);
    rst = 1'b1;
    step(4);
    chk("rst_discard_req", {31'd0, C}, 32'd0);

    p0 = pulses;
    for (int k = 0; k < 3; k++) serve_cycle(k);
    chk("served_total_3", pulses - p0, 32'd3);
`ifdef FARM_REQ_STATS_EN
    chk("req_count_3", {16'd0, req_count}, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
